// File: rtl/pipe_sched.sv
// Pipeline sequencer for the 5-stage RV64 core: bus handshakes, load-use stall,
// pcsrc redirect and per-stage enable/bubble generation. Optional PIPE_SCHED_PERF_EN adds perf counters.
module pipe_sched #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             i_req,
  input  logic             i_data_ok,
  output logic             d_req,
  input  logic             d_data_ok,
  input  logic             mem_access,
  input  logic [4:0]       id_ra1,
  input  logic [4:0]       id_ra2,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [4:0]       ex_dst,
  input  logic             redirect,
  output logic             en_pc,
  output logic             en_id,
  output logic             en_ex,
  output logic             en_mem,
  output logic             en_wb,
  output logic             bubble_ex,
  output logic             flush_id
`ifdef PIPE_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_cycles,
  output logic [CNT_W-1:0] perf_istall,
  output logic [CNT_W-1:0] perf_dstall,
  output logic [CNT_W-1:0] perf_lu
`endif
);

  typedef enum logic [1:0] {I_IDLE, I_REQ, I_HOLD} istate_t;
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_DONE} dstate_t;

  istate_t istate, istate_nxt;
  dstate_t dstate, dstate_nxt;
  logic    drop, drop_nxt;

  logic mem_ok, if_ok, adv, lu, redir, take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      istate <= I_IDLE;
      dstate <= D_IDLE;
      drop   <= 1'b0;
    end else begin
      istate <= istate_nxt;
      dstate <= dstate_nxt;
      drop   <= drop_nxt;
    end
  end

  always_comb begin
    istate_nxt = istate;
    dstate_nxt = dstate;
    drop_nxt   = drop;

    mem_ok = !mem_access || d_data_ok || (dstate == D_DONE);
    if_ok  = (istate == I_HOLD) || ((istate == I_REQ) && i_data_ok && !drop);
    adv    = mem_ok && if_ok;
    lu     = ex_valid && ex_memread && (ex_dst != 5'd0) &&
             ((ex_dst == id_ra1) || (ex_dst == id_ra2));
    redir  = redirect && mem_ok;
    // The fetch side only hands a word over when decode actually loads it,
    // so a load-use stall keeps the returned word parked in HOLD.
    take   = (adv && !lu) || redir;

    // Outputs are forced low while reset is asserted, independent of the clock.
    i_req     = !reset && (istate == I_REQ);
    d_req     = !reset && ((dstate == D_WAIT) || ((dstate == D_IDLE) && mem_access));
    en_pc     = !reset && take;
    en_id     = !reset && take;
    en_ex     = !reset && mem_ok;
    en_mem    = !reset && mem_ok;
    en_wb     = !reset && mem_ok;
    bubble_ex = !reset && mem_ok && (lu || redirect || !if_ok);
    flush_id  = !reset && redir;

    case (istate)
      I_IDLE: istate_nxt = I_REQ;
      I_REQ: begin
        if (i_data_ok) begin
          if (drop)       drop_nxt   = 1'b0;
          else if (!take) istate_nxt = I_HOLD;
        end else if (redir) begin
          drop_nxt = 1'b1;
        end
      end
      I_HOLD: if (take) istate_nxt = I_REQ;
      default: istate_nxt = I_IDLE;
    endcase

    case (dstate)
      D_IDLE: if (mem_access) dstate_nxt = d_data_ok ? D_DONE : D_WAIT;
      D_WAIT: if (d_data_ok)  dstate_nxt = D_DONE;
      D_DONE: if (mem_ok)     dstate_nxt = D_IDLE;
      default: dstate_nxt = D_IDLE;
    endcase
  end

`ifdef PIPE_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_istall <= '0;
      perf_dstall <= '0;
      perf_lu     <= '0;
    end else begin
      perf_cycles <= perf_cycles + CNT_W'(1);
      if (!if_ok)       perf_istall <= perf_istall + CNT_W'(1);
      if (!mem_ok)      perf_dstall <= perf_dstall + CNT_W'(1);
      if (lu && mem_ok) perf_lu     <= perf_lu + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// Directed self-checking bench for pipe_sched; outputs compared as one packed vector
// {i_req,d_req,en_pc,en_id,en_ex,en_mem,en_wb,bubble_ex,flush_id}.
module tb_pipe_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic       i_req, i_data_ok, d_req, d_data_ok, mem_access;
  logic [4:0] id_ra1, id_ra2, ex_dst;
  logic       ex_valid, ex_memread, redirect;
  logic       en_pc, en_id, en_ex, en_mem, en_wb, bubble_ex, flush_id;
`ifdef PIPE_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_istall, perf_dstall, perf_lu;
`endif
  logic [8:0] outs;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign outs = {i_req, d_req, en_pc, en_id, en_ex, en_mem, en_wb, bubble_ex, flush_id};

  pipe_sched #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_data_ok(i_data_ok),
    .d_req(d_req), .d_data_ok(d_data_ok),
    .mem_access(mem_access),
    .id_ra1(id_ra1), .id_ra2(id_ra2),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_dst(ex_dst),
    .redirect(redirect),
    .en_pc(en_pc), .en_id(en_id), .en_ex(en_ex), .en_mem(en_mem), .en_wb(en_wb),
    .bubble_ex(bubble_ex), .flush_id(flush_id)
`ifdef PIPE_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_istall(perf_istall),
    .perf_dstall(perf_dstall), .perf_lu(perf_lu)
`endif
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; i_data_ok = 1'b1; d_data_ok = 1'b1; mem_access = 1'b1;
    id_ra1 = 5'd1; id_ra2 = 5'd2; ex_valid = 1'b0; ex_memread = 1'b0;
    ex_dst = 5'd0; redirect = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    checks++;
    if (outs !== 9'b000000000) begin
      errors++; $display("FAIL reset_outs: got %b expected %b", outs, 9'b000000000);
    end
    mem_access = 1'b0;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 9'b000011110) begin
      errors++; $display("FAIL reset_first_cycle: got %b expected %b", outs, 9'b000011110);
    end
    cyc();
  endtask

  task automatic test_zero_wait;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== 9'b101111100) begin
        errors++; $display("FAIL zero_wait[%0d]: got %b expected %b", i, outs, 9'b101111100);
      end
      cyc();
    end
  endtask

  task automatic test_load_use;
    ex_valid = 1'b1; ex_memread = 1'b1; ex_dst = 5'd5; id_ra1 = 5'd3; id_ra2 = 5'd5;
    @(negedge clk);
    checks++;
    if (outs !== 9'b100011110) begin
      errors++; $display("FAIL lu_stall: got %b expected %b", outs, 9'b100011110);
    end
    cyc();
    ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 9'b001111100) begin
      errors++; $display("FAIL lu_release_hold: got %b expected %b", outs, 9'b001111100);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (outs !== 9'b101111100) begin
      errors++; $display("FAIL lu_refetch: got %b expected %b", outs, 9'b101111100);
    end
    cyc();
  endtask

  task automatic test_lu_corners;
    ex_valid = 1'b1; ex_memread = 1'b1; ex_dst = 5'd0; id_ra1 = 5'd0; id_ra2 = 5'd0;
    @(negedge clk);
    checks++;
    if (outs !== 9'b101111100) begin
      errors++; $display("FAIL lu_x0: got %b expected %b", outs, 9'b101111100);
    end
    cyc();
    ex_memread = 1'b0; ex_dst = 5'd5; id_ra1 = 5'd5;
    @(negedge clk);
    checks++;
    if (outs !== 9'b101111100) begin
      errors++; $display("FAIL lu_not_load: got %b expected %b", outs, 9'b101111100);
    end
    cyc();
    ex_memread = 1'b1; ex_dst = 5'd7; id_ra1 = 5'd7; id_ra2 = 5'd1;
    @(negedge clk);
    checks++;
    if (outs !== 9'b100011110) begin
      errors++; $display("FAIL lu_ra1: got %b expected %b", outs, 9'b100011110);
    end
    cyc();
    ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 9'b001111100) begin
      errors++; $display("FAIL lu_ra1_release: got %b expected %b", outs, 9'b001111100);
    end
    cyc();
  endtask

  task automatic test_dmem_wait;
    logic [8:0] exp;
    mem_access = 1'b1; d_data_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) d_data_ok = 1'b1;
      exp = (i == 0) ? 9'b110000000 : (i == 3) ? 9'b011111100 : 9'b010000000;
      @(negedge clk);
      checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL dmem_wait[%0d]: got %b expected %b", i, outs, exp);
      end
      cyc();
    end
    mem_access = 1'b0; d_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 9'b101111100) begin
      errors++; $display("FAIL dmem_after: got %b expected %b", outs, 9'b101111100);
    end
    cyc();
    d_data_ok = 1'b1;
  endtask

  task automatic test_redirect_pending;
    logic [8:0] exp [5] = '{9'b100011110, 9'b101111111, 9'b100011110,
                            9'b100011110, 9'b101111100};
    for (int i = 0; i < 5; i++) begin
      i_data_ok = (i >= 3);
      redirect  = (i == 1);
      @(negedge clk);
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL redirect_pending[%0d]: got %b expected %b", i, outs, exp[i]);
      end
      cyc();
    end
    redirect = 1'b0; i_data_ok = 1'b1;
  endtask

  task automatic test_redirect_hold;
    ex_valid = 1'b1; ex_memread = 1'b1; ex_dst = 5'd9; id_ra1 = 5'd9;
    @(negedge clk);
    checks++;
    if (outs !== 9'b100011110) begin
      errors++; $display("FAIL rh_lu: got %b expected %b", outs, 9'b100011110);
    end
    cyc();
    redirect = 1'b1; mem_access = 1'b1; d_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 9'b010000000) begin
      errors++; $display("FAIL rh_held_by_mem: got %b expected %b", outs, 9'b010000000);
    end
    cyc();
    d_data_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 9'b011111111) begin
      errors++; $display("FAIL rh_redirect_over_lu: got %b expected %b", outs, 9'b011111111);
    end
    cyc();
    redirect = 1'b0; ex_valid = 1'b0; mem_access = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 9'b101111100) begin
      errors++; $display("FAIL rh_refetch: got %b expected %b", outs, 9'b101111100);
    end
    cyc();
  endtask

  task automatic test_reset_mid_wait;
    mem_access = 1'b1; d_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 9'b110000000) begin
      errors++; $display("FAIL rw_enter: got %b expected %b", outs, 9'b110000000);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (outs !== 9'b010000000) begin
      errors++; $display("FAIL rw_wait: got %b expected %b", outs, 9'b010000000);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs !== 9'b000000000) begin
      errors++; $display("FAIL rw_async_reset: got %b expected %b", outs, 9'b000000000);
    end
    mem_access = 1'b0;
    cyc();
    reset = 1'b0; d_data_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== 9'b000011110) begin
      errors++; $display("FAIL rw_late_ok: got %b expected %b", outs, 9'b000011110);
    end
    cyc();
    mem_access = 1'b1; d_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== 9'b110000000) begin
      errors++; $display("FAIL rw_dside_idle: got %b expected %b", outs, 9'b110000000);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_load_use();
    test_lu_corners();
    test_dmem_wait();
    test_redirect_pending();
    test_redirect_hold();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish before 100000");
    $fatal(1);
  end
endmodule

// File: doc/pipe_sched.md
Name: pipe_sched

Overview:
- Central sequencer for the 5-stage RV64 pipeline (fetch/decode/execute/memory/writeback stage registers).
- Owns the instruction-bus and data-bus request handshakes.
- Detects load-use hazards and applies pcsrc redirects.
- Drives per-stage enable and bubble signals so the stage registers advance, hold or squash in lockstep.

Parameters:
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- i_req  out  1  instruction fetch request, held until i_data_ok
- i_data_ok  in  1  instruction data returned this cycle
- d_req  out  1  data access request, held until d_data_ok
- d_data_ok  in  1  data access completed this cycle
- mem_access  in  1  memory-stage instruction is valid and has memread or memwrite set
- id_ra1, id_ra2  in  5  decode-stage source register addresses
- ex_valid  in  1  execute-stage instruction valid
- ex_memread  in  1  execute-stage instruction is a load
- ex_dst  in  5  execute-stage destination register
- redirect  in  1  pcsrc asserted by a valid execute-stage instruction
- en_pc, en_id, en_ex, en_mem, en_wb  out  1  stage register load enables
- bubble_ex  out  1  load an invalid entry into the execute register
- flush_id  out  1  load an invalid entry into the decode register

Behaviour:
- Reset (async, immediate): i_req=0, d_req=0, all en_*=0, bubble_ex=0, flush_id=0; both FSMs in IDLE; drop flag cleared.

I-side FSM:
- IDLE -> REQ on the first clock after reset release. i_req=1 in REQ.
- REQ, i_data_ok=1, drop=0: -> HOLD if the pipeline does not advance this cycle; otherwise stay REQ and issue the next fetch.
- REQ, i_data_ok=1, drop=1: clear drop, stay REQ. The stale word is discarded; en_pc is not asserted for it.
- HOLD: i_req=0, word buffered externally. On an advance -> REQ.

D-side FSM:
- IDLE: d_req=mem_access. mem_access & d_data_ok in the same cycle -> DONE.
- mem_access & !d_data_ok -> WAIT.
- WAIT: d_req=1. On d_data_ok -> DONE.
- DONE: d_req=0. On an advance -> IDLE.
- mem_access=0 in IDLE: no request.

Advance conditions:
- mem_ok = !mem_access | d_data_ok | (dstate==DONE).
- if_ok = (istate==HOLD) | (istate==REQ & i_data_ok & !drop).
- adv = mem_ok & if_ok.

Load-use hazard:
- lu = ex_valid & ex_memread & ex_dst!=0 & (ex_dst==id_ra1 | ex_dst==id_ra2).

Outputs (combinational from state and inputs):
- en_wb = en_mem = mem_ok.
- en_ex = mem_ok.
- bubble_ex = mem_ok & (lu | redirect | !if_ok).
- en_pc = en_id = adv & !lu, or redirect & mem_ok.
- flush_id = redirect & mem_ok.
- Backend stages advance even when fetch stalls; a bubble enters execute instead.

Redirect:
- redirect & mem_ok while istate==REQ & !i_data_ok: set drop; the outstanding fetch is killed on return.
- Redirect in HOLD: discard the buffer; -> REQ next cycle.
- Redirect takes priority over lu.
- Redirect with !mem_ok is held by the execute stage until mem_ok.

Latency:
- With zero-wait buses, one instruction enters decode per cycle.
- Load-use costs exactly one bubble.

Protocol and reset rules:
- i_req and d_req are never deasserted before their data_ok.
- Reset mid-handshake returns both FSMs to IDLE; a late data_ok after reset is ignored.

Optional Feature:
- Macro: PIPE_SCHED_PERF_EN.
- Defined:
  - adds outputs perf_cycles, perf_istall, perf_dstall, perf_lu (CNT_W each).
  - Counters reset to 0 and increment per cycle on: any cycle, !if_ok, !mem_ok, lu & mem_ok respectively.
  - Counters wrap modulo 2^CNT_W.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Zero-wait buses (i_data_ok, d_data_ok tied 1), 10 independent ALU ops -> en_pc=1 every cycle from cycle 2 after reset; no bubble_ex.
- ex_valid=1, ex_memread=1, ex_dst=5, id_ra2=5 -> exactly one cycle with en_pc=0, en_id=0, bubble_ex=1; next cycle lu=0, normal advance.
- ex_dst=0 with id_ra1=0 and ex_memread=1 -> no stall.
- mem_access=1, d_data_ok arriving 3 cycles late -> d_req high for 4 cycles, en_ex/en_mem/en_wb=0 for 3 cycles, then one advance and d_req=0.
- redirect=1 while i_req pending with i_data_ok delayed 2 cycles -> flush_id=1 for one cycle; first returned word dropped (no en_pc); new i_req issued the following cycle.
- reset asserted during D-side WAIT -> d_req=0 immediately with no clock edge; after release, d_data_ok=1 with mem_access=0 causes no state change.
